// File: rtl/lc4_writeback_stage.sv
// -----------------------------------------------------------------------------
// lc4_writeback_stage
//   Single-entry pipeline stage behind lc4_alu. Holds one ALU result together
//   with its instruction and PC, and on the retire edge commits NZP/carry flags,
//   the illegal-opcode sticky bit and the retired-instruction counter. Register
//   writes and branch/jump redirects are presented combinationally while the
//   instruction is held and take effect when the register file accepts it.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   i_valid/o_ready  upstream handshake (ALU result in)
//   i_insn, i_pc     instruction (opcode [INSN:INSN-4], rd [INSN-5:INSN-9]) and PC
//   i_result         ALU result
//   o_valid          held instruction presented downstream
//   i_wb_ready       register file accepts this cycle (retire = o_valid & i_wb_ready)
//   o_wr_en/addr/data register-file write port
//   o_carry, o_nzp   committed flags (o_carry feeds the ALU carry input)
//   o_flag_pending   held instruction will update carry or NZP
//   o_redirect       taken branch/jump retiring this cycle, to o_target
//   o_illegal        sticky: an unknown opcode has retired
//   o_retired        retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module lc4_writeback_stage #(
   parameter int unsigned WORD_SIZE = 256,
   parameter int unsigned INSN      = 19,
   parameter int unsigned IADDR     = 10,
   parameter int unsigned DADDR     = 4,
   parameter int unsigned LINK_REG  = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [INSN:0]        i_insn,
   input  logic [IADDR:0]       i_pc,
   input  logic [WORD_SIZE-1:0] i_result,
   output logic                 o_valid,
   input  logic                 i_wb_ready,
   output logic                 o_wr_en,
   output logic [DADDR:0]       o_wr_addr,
   output logic [WORD_SIZE-1:0] o_wr_data,
   output logic                 o_carry,
   output logic [2:0]           o_nzp,
   output logic                 o_flag_pending,
   output logic                 o_redirect,
   output logic [IADDR:0]       o_target,
   output logic                 o_illegal,
   output logic [31:0]          o_retired
);

   typedef enum logic [4:0] {
      OP_NOP    = 5'b00000,
      OP_BRZ    = 5'b00001,
      OP_BRZP   = 5'b00010,
      OP_BRNP   = 5'b00011,
      OP_BRNZ   = 5'b00100,
      OP_ALU_05 = 5'b00101,
      OP_ALU_06 = 5'b00110,
      OP_ALU_07 = 5'b00111,
      OP_JSR    = 5'b01000,
      OP_ALU_09 = 5'b01001,
      OP_RTI    = 5'b01010,
      OP_ALU_0B = 5'b01011,
      OP_ALU_0C = 5'b01100,
      OP_ALU_0D = 5'b01101,
      OP_ALU_0E = 5'b01110,
      OP_ALU_0F = 5'b01111,
      OP_CHKL   = 5'b10000,
      OP_ALU_12 = 5'b10010,
      OP_CHKH   = 5'b10011,
      OP_ALU_14 = 5'b10100,
      OP_ALU_15 = 5'b10101
   } op_e;

   localparam logic [DADDR:0] LINK_ADDR = LINK_REG[DADDR:0];
   localparam logic [IADDR:0] PC_ONE    = {{IADDR{1'b0}}, 1'b1};

   // Held instruction state
   logic                 valid_q;
   logic [4:0]           op_q;
   logic [DADDR:0]       rd_q;
   logic [IADDR:0]       pc_q;
   logic [WORD_SIZE-1:0] res_q;

   // Instruction bits below rd carry nothing this stage needs
   logic insn_unused;
   assign insn_unused = ^i_insn[INSN-DADDR-6:0];

   // Decode of the held opcode
   logic is_alu, is_chkl, is_chkh, is_jsr, is_illegal, br_taken, redirect_held;
   logic res_n, res_z, res_p;
   logic [IADDR:0] pc_inc;

   assign res_n  = res_q[WORD_SIZE-1];
   assign res_z  = (res_q == '0);
   assign res_p  = !res_n && !res_z;
   assign pc_inc = pc_q + PC_ONE;

   always_comb begin
      is_alu        = 1'b0;
      is_chkl       = 1'b0;
      is_chkh       = 1'b0;
      is_jsr        = 1'b0;
      is_illegal    = 1'b0;
      br_taken      = 1'b0;
      redirect_held = 1'b0;
      case (op_q)
         OP_NOP: ;
         OP_BRZ:  br_taken = o_nzp[1];
         OP_BRZP: br_taken = o_nzp[1] | o_nzp[0];
         OP_BRNP: br_taken = o_nzp[2] | o_nzp[0];
         OP_BRNZ: br_taken = o_nzp[2] | o_nzp[1];
         OP_ALU_05, OP_ALU_06, OP_ALU_07, OP_ALU_09, OP_ALU_0B, OP_ALU_0C,
         OP_ALU_0D, OP_ALU_0E, OP_ALU_0F, OP_ALU_12, OP_ALU_14, OP_ALU_15:
            is_alu = 1'b1;
         OP_JSR:  is_jsr = 1'b1;
         OP_RTI:  redirect_held = 1'b1;
         OP_CHKL: is_chkl = 1'b1;
         OP_CHKH: is_chkh = 1'b1;
         default: is_illegal = 1'b1;
      endcase
      redirect_held = redirect_held | br_taken | is_jsr;
   end

   logic load, retire;
   assign o_ready = !valid_q | i_wb_ready;
   assign o_valid = valid_q;
   assign retire  = valid_q & i_wb_ready;
   assign load    = i_valid & o_ready;

   assign o_flag_pending = valid_q & (is_alu | is_chkl | is_chkh);
   assign o_wr_en        = retire & (is_alu | is_jsr);
   assign o_redirect     = retire & redirect_held;

   // Write/target buses derive only from held registers, so they keep their
   // last values after the instruction retires and the stage goes idle.
   assign o_wr_addr = is_jsr ? LINK_ADDR : rd_q;
   assign o_wr_data = is_jsr ? {{(WORD_SIZE-IADDR-1){1'b0}}, pc_inc} : res_q;
   assign o_target  = res_q[IADDR:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         op_q      <= '0;
         rd_q      <= '0;
         pc_q      <= '0;
         res_q     <= '0;
         o_carry   <= 1'b0;
         o_nzp     <= 3'b010;
         o_illegal <= 1'b0;
         o_retired <= '0;
      end else begin
         if (retire) begin
            o_retired <= o_retired + 32'd1;
            if (is_alu)     o_nzp     <= {res_n, res_z, res_p};
            if (is_chkl)    o_carry   <= res_q[0];
            if (is_chkh)    o_carry   <= res_q[WORD_SIZE-1];
            if (is_illegal) o_illegal <= 1'b1;
         end
         if (load) begin
            valid_q <= 1'b1;
            op_q    <= i_insn[INSN -: 5];
            rd_q    <= i_insn[INSN-5 -: DADDR+1];
            pc_q    <= i_pc;
            res_q   <= i_result;
         end else if (retire) begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lc4_writeback_stage.sv
module tb_lc4_writeback_stage;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_valid;
   logic         o_ready;
   logic [19:0]  i_insn;
   logic [10:0]  i_pc;
   logic [255:0] i_result;
   logic         o_valid;
   logic         i_wb_ready;
   logic         o_wr_en;
   logic [4:0]   o_wr_addr;
   logic [255:0] o_wr_data;
   logic         o_carry;
   logic [2:0]   o_nzp;
   logic         o_flag_pending;
   logic         o_redirect;
   logic [10:0]  o_target;
   logic         o_illegal;
   logic [31:0]  o_retired;

   int total = 0;
   int bad   = 0;

   lc4_writeback_stage #(.WORD_SIZE(256), .INSN(19), .IADDR(10), .DADDR(4), .LINK_REG(7)) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_insn(i_insn), .i_pc(i_pc), .i_result(i_result), .o_valid(o_valid),
      .i_wb_ready(i_wb_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
      .o_wr_data(o_wr_data), .o_carry(o_carry), .o_nzp(o_nzp),
      .o_flag_pending(o_flag_pending), .o_redirect(o_redirect), .o_target(o_target),
      .o_illegal(o_illegal), .o_retired(o_retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for exactly one edge; afterwards it is held.
   task automatic issue(input logic [4:0] op, input logic [4:0] rd,
                        input logic [10:0] pc, input logic [255:0] r);
      @(negedge clk);
      i_valid  = 1'b1;
      i_insn   = {op, rd, 10'b0};
      i_pc     = pc;
      i_result = r;
      tick();
      i_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; i_valid = 1'b0; i_wb_ready = 1'b1;
      i_insn = '0; i_pc = '0; i_result = '0;
      #12;
      chk("rst_valid",   o_valid, 0);
      chk("rst_ready",   o_ready, 1);
      chk("rst_carry",   o_carry, 0);
      chk("rst_nzp",     o_nzp, 3'b010);
      chk("rst_illegal", o_illegal, 0);
      chk("rst_retired", o_retired, 0);
      chk("rst_wr_en",   o_wr_en, 0);
      chk("rst_redir",   o_redirect, 0);
      chk("rst_fpend",   o_flag_pending, 0);
      @(negedge clk); rst_n = 1'b1;

      // ADD rd=3 result 5
      issue(5'b00101, 5'd3, 11'h010, 256'd5);
      chk("add_valid", o_valid, 1);
      chk("add_wr_en", o_wr_en, 1);
      chk("add_addr",  o_wr_addr, 3);
      chk("add_data",  o_wr_data, 5);
      chk("add_fpend", o_flag_pending, 1);
      chk("add_redir", o_redirect, 0);
      tick();
      chk("add_nzp",     o_nzp, 3'b001);
      chk("add_retired", o_retired, 1);
      chk("add_idle_wr", o_wr_en, 0);
      chk("add_hold_ad", o_wr_addr, 3);
      chk("add_hold_dt", o_wr_data, 5);

      // CHKL all-ones -> carry 1
      issue(5'b10000, 5'd0, 11'h011, '1);
      chk("chkl_fpend", o_flag_pending, 1);
      chk("chkl_wr_en", o_wr_en, 0);
      tick();
      chk("chkl_carry", o_carry, 1);
      chk("chkl_nzp",   o_nzp, 3'b001);

      // CHKH zero -> carry 0
      issue(5'b10011, 5'd0, 11'h012, 256'd0);
      chk("chkh_fpend", o_flag_pending, 1);
      chk("chkh_wr_en", o_wr_en, 0);
      tick();
      chk("chkh_carry", o_carry, 0);
      chk("chkh_ret",   o_retired, 3);

      // SUB result -1 -> negative
      issue(5'b00110, 5'd1, 11'h013, '1);
      chk("sub_data", o_wr_data, {256{1'b1}});
      tick();
      chk("sub_nzp", o_nzp, 3'b100);

      // BRnz taken (n set)
      issue(5'b00100, 5'd0, 11'h014, 256'h040);
      chk("brnz_redir",  o_redirect, 1);
      chk("brnz_target", o_target, 11'h040);
      chk("brnz_wr_en",  o_wr_en, 0);
      chk("brnz_fpend",  o_flag_pending, 0);
      tick();
      chk("brnz_pulse",  o_redirect, 0);
      chk("brnz_nzp",    o_nzp, 3'b100);

      // BRz not taken (n set, z clear)
      issue(5'b00001, 5'd0, 11'h015, 256'h123);
      chk("brz_redir", o_redirect, 0);
      tick();
      chk("brz_ret", o_retired, 6);

      // JSR from 0x7FF: link wraps to 0
      issue(5'b01000, 5'd9, 11'h7FF, 256'h010);
      chk("jsr_redir",  o_redirect, 1);
      chk("jsr_target", o_target, 11'h010);
      chk("jsr_wr_en",  o_wr_en, 1);
      chk("jsr_addr",   o_wr_addr, 7);
      chk("jsr_data",   o_wr_data, 0);
      tick();
      chk("jsr_ret", o_retired, 7);

      // Backpressure: A loads, B waits 4 cycles, then both flow
      @(negedge clk);
      i_wb_ready = 1'b0; i_valid = 1'b1;
      i_insn = {5'b00101, 5'd2, 10'b0}; i_result = 256'hA;
      tick();
      i_insn = {5'b00101, 5'd4, 10'b0}; i_result = 256'hB;
      for (int i = 0; i < 4; i++) begin
         chk("stall_ready", o_ready, 0);
         chk("stall_wr_en", o_wr_en, 0);
         chk("stall_data",  o_wr_data, 256'hA);
         chk("stall_valid", o_valid, 1);
         tick();
      end
      chk("stall_ret", o_retired, 7);
      i_wb_ready = 1'b1;
      #1;
      chk("rel_wr_en_a", o_wr_en, 1);
      chk("rel_data_a",  o_wr_data, 256'hA);
      tick();
      chk("rel_data_b",  o_wr_data, 256'hB);
      chk("rel_addr_b",  o_wr_addr, 4);
      chk("rel_wr_en_b", o_wr_en, 1);
      chk("rel_ret_a",   o_retired, 8);
      i_valid = 1'b0;
      tick();
      chk("rel_ret_b", o_retired, 9);
      chk("rel_idle",  o_valid, 0);

      // Illegal opcode is sticky
      issue(5'b11111, 5'd6, 11'h020, 256'h55);
      chk("ill_wr_en", o_wr_en, 0);
      chk("ill_redir", o_redirect, 0);
      tick();
      chk("ill_flag", o_illegal, 1);
      issue(5'b00000, 5'd0, 11'h021, 256'h0);
      tick();
      chk("ill_sticky", o_illegal, 1);
      chk("nop_ret",    o_retired, 11);

      // Set carry, then reset while an ADD is stalled
      issue(5'b10000, 5'd0, 11'h022, 256'h1);
      tick();
      chk("pre_carry", o_carry, 1);
      i_wb_ready = 1'b0;
      issue(5'b00101, 5'd5, 11'h023, 256'h77);
      chk("pre_valid", o_valid, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_valid",   o_valid, 0);
      chk("mrst_wr_en",   o_wr_en, 0);
      chk("mrst_carry",   o_carry, 0);
      chk("mrst_nzp",     o_nzp, 3'b010);
      chk("mrst_illegal", o_illegal, 0);
      chk("mrst_retired", o_retired, 0);
      chk("mrst_data",    o_wr_data, 0);
      chk("mrst_ready",   o_ready, 1);
      i_wb_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_retired", o_retired, 0);
      chk("post_redir",   o_redirect, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
